// File: rtl/sa_fifo_pkg.sv
// Shared constants and types for the systolic-array feed FIFO controller.
package sa_fifo_pkg;

    localparam int DEPTH_DEF = 64;
    localparam int AW_DEF    = 6;
    localparam int DW_DEF    = 512;

    // RAM address / pointer
    typedef logic [AW_DEF-1:0] ptr_t;
    // Occupancy count: needs one extra bit to represent a full RAM (and RAM + buffer)
    typedef logic [AW_DEF:0]   cnt_t;

endpackage

// File: rtl/sa_fifo_skid2.sv
// Two-entry output buffer: captures RAM read data and presents it as a
// valid/ready stream with no bubbles between back-to-back entries.
module sa_fifo_skid2
    import sa_fifo_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_pd,
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [DW-1:0] out_pd,
    output logic [1:0]    buf_cnt
);

    logic          head;
    logic          tail;
    logic          pop;
    logic [DW-1:0] ent0;
    logic [DW-1:0] ent1;

    assign out_vld = (buf_cnt != 2'd0);
    assign pop     = out_vld && out_rdy;
    // Data registers are not reset; the output is forced to zero while empty
    assign out_pd  = out_vld ? (head ? ent1 : ent0) : '0;

    // Head/tail slot selects and occupancy; push and pop may happen together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head    <= 1'b0;
            tail    <= 1'b0;
            buf_cnt <= 2'd0;
        end else begin
            if (push) tail <= ~tail;
            if (pop)  head <= ~head;
            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Capture incoming RAM data into the tail slot
    always_ff @(posedge clk) begin
        if (push) begin
            if (tail) ent1 <= push_pd;
            else      ent0 <= push_pd;
        end
    end

endmodule

// File: rtl/sa_ram_fifo_ctrl.sv
// Valid/ready FIFO controller around a dual-port RAM with a registered read
// address. Owns the pointers and occupancy, issues RAM reads only when the
// output buffer is guaranteed room, and streams data out through a 2-entry
// buffer so the consumer sees one beat per cycle in steady state.
module sa_ram_fifo_ctrl
    import sa_fifo_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_pvld,
    output logic          wr_prdy,
    input  logic [DW-1:0] wr_pd,
    output logic          rd_pvld,
    input  logic          rd_prdy,
    output logic [DW-1:0] rd_pd,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_di,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout,
    output logic [AW:0]   count
);

    localparam int CW = AW + 1;

    logic          wr_acc;
    logic          pop;
    logic          inflight;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   ram_cnt;
    logic [AW:0]   ram_cnt_nxt;
    logic [1:0]    buf_cnt;
    logic [2:0]    occ;

    assign wr_acc = wr_pvld && wr_prdy;
    assign pop    = rd_pvld && rd_prdy;

    // RAM write port follows the accepted producer beat directly
    assign ram_we = wr_acc;
    assign ram_wa = wptr;
    assign ram_di = wr_pd;

    // Buffer slots already claimed (held + arriving next edge). A read is only
    // issued if its data is guaranteed a slot, counting a same-cycle pop.
    // Only the registered ram_cnt is used, so a same-cycle write is never read.
    assign occ    = {1'b0, buf_cnt} + {2'b00, inflight};
    assign ram_re = (ram_cnt != '0) && (occ < (3'd2 + {2'b00, pop}));
    assign ram_ra = rptr;

    assign ram_cnt_nxt = ram_cnt + CW'(wr_acc) - CW'(ram_re);

    assign count = ram_cnt + CW'(inflight) + CW'(buf_cnt);

    // Pointers, RAM occupancy, read-in-flight flag and registered write-ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            wr_prdy  <= 1'b0;
        end else begin
            if (wr_acc) wptr <= wptr + AW'(1);
            if (ram_re) rptr <= rptr + AW'(1);
            ram_cnt  <= ram_cnt_nxt;
            inflight <= ram_re;
            wr_prdy  <= (ram_cnt_nxt < CW'(DEPTH));
        end
    end

    sa_fifo_skid2 #(
        .DW (DW)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push    (inflight),
        .push_pd (ram_dout),
        .out_vld (rd_pvld),
        .out_rdy (rd_prdy),
        .out_pd  (rd_pd),
        .buf_cnt (buf_cnt)
    );

endmodule

// File: tb/tb_sa_ram_fifo_ctrl.sv
// Bench for sa_ram_fifo_ctrl: RAM model, queue scoreboard, vector table and
// directed/random sequences.
module tb_sa_ram_fifo_ctrl;
    import sa_fifo_pkg::*;

    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int DW    = 512;

    logic          clk;
    logic          rst;
    logic          wr_pvld;
    logic          wr_prdy;
    logic [DW-1:0] wr_pd;
    logic          rd_pvld;
    logic          rd_prdy;
    logic [DW-1:0] rd_pd;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_di;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;
    logic [AW:0]   count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_acc    = 0;
    int n_pop    = 0;

    logic [DW-1:0] sb_q[$];
    logic [DW-1:0] cur_data;
    int            seq_val;
    bit            rand_mode;

    sa_ram_fifo_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_pvld  (wr_pvld),
        .wr_prdy  (wr_prdy),
        .wr_pd    (wr_pd),
        .rd_pvld  (rd_pvld),
        .rd_prdy  (rd_prdy),
        .rd_pd    (rd_pd),
        .ram_we   (ram_we),
        .ram_wa   (ram_wa),
        .ram_di   (ram_di),
        .ram_re   (ram_re),
        .ram_ra   (ram_ra),
        .ram_dout (ram_dout),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Dual-port RAM model, registered read
    logic [DW-1:0] ram_mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
        ram_dout = '0;
    end
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_wa] <= ram_di;
        if (ram_re) ram_dout <= ram_mem[ram_ra];
    end

    task automatic check_i(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_d(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: accepted writes queue up, every pop must match the oldest
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (rd_pvld && rd_prdy) begin
                n_pop++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL pop_empty: got %0h expected no output (t=%0t)", rd_pd, $time);
                end else begin
                    check_d("rd_pd_order", rd_pd, sb_q.pop_front());
                end
            end
            if (wr_pvld && wr_prdy) sb_q.push_back(wr_pd);
            if (ram_we && ram_re) check_i("ram_addr_hazard", int'(ram_wa != ram_ra), 1);
        end
    end

    function automatic logic [DW-1:0] next_data();
        logic [DW-1:0] d;
        if (rand_mode) begin
            for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
        end else begin
            seq_val++;
            d = DW'(seq_val);
        end
        return d;
    endfunction

    task automatic set_seq(input int start);
        rand_mode = 1'b0;
        seq_val   = start;
        cur_data  = DW'(start);
    endtask

    // One cycle of stimulus, driven on the falling edge
    task automatic step(input bit wv, input bit rr);
        @(negedge clk);
        wr_pvld = wv;
        rd_prdy = rr;
        wr_pd   = cur_data;
        if (wv && wr_prdy) begin
            n_acc++;
            cur_data = next_data();
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        wr_pvld = 1'b0;
        rd_prdy = 1'b0;
        wr_pd   = '0;
        #1;
        check_i("rst_wr_prdy", int'(wr_prdy), 0);
        check_i("rst_rd_pvld", int'(rd_pvld), 0);
        check_i("rst_count", int'(count), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while ((sb_q.size() != 0 || rd_pvld) && k < 400) begin
            step(1'b0, 1'b1);
            k++;
        end
        check_i({name, "_drain_bound"}, int'(k < 400), 1);
        step(1'b0, 1'b0);
        check_i({name, "_end_count"}, int'(count), 0);
        check_i({name, "_end_rd_pvld"}, int'(rd_pvld), 0);
    endtask

    typedef struct {
        bit       wv;
        bit       rr;
        int       d;
        bit       e_prdy;
        bit       e_vld;
        int       e_cnt;
        int       e_pd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int steady;
        int pop0;

        // Expected state seen in each cycle before that cycle's inputs act
        tbl[0] = '{0, 1, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 1, 1, 0, 0, 0};
        tbl[2] = '{1, 1, 2, 1, 0, 1, 0};
        tbl[3] = '{1, 1, 3, 1, 0, 2, 0};
        tbl[4] = '{0, 1, 0, 1, 1, 3, 1};
        tbl[5] = '{0, 1, 0, 1, 1, 2, 2};
        tbl[6] = '{0, 1, 0, 1, 1, 1, 3};
        tbl[7] = '{0, 1, 0, 1, 0, 0, 0};

        set_seq(1);
        do_reset();

        // Short burst: latency and back-to-back output
        for (int i = 0; i < 8; i++) begin
            check_i($sformatf("tbl%0d_wr_prdy", i), int'(wr_prdy), int'(tbl[i].e_prdy));
            check_i($sformatf("tbl%0d_rd_pvld", i), int'(rd_pvld), int'(tbl[i].e_vld));
            check_i($sformatf("tbl%0d_count", i), int'(count), tbl[i].e_cnt);
            if (tbl[i].e_vld) check_d($sformatf("tbl%0d_rd_pd", i), rd_pd, DW'(tbl[i].e_pd));
            wr_pvld = tbl[i].wv;
            rd_prdy = tbl[i].rr;
            wr_pd   = DW'(tbl[i].d);
            @(negedge clk);
        end
        wr_pvld = 1'b0;

        // Fill to 66 with the consumer stalled
        do_reset();
        set_seq(1);
        n_acc = 0;
        k = 0;
        while (n_acc < 66 && k < 300) begin
            step(1'b1, 1'b0);
            k++;
        end
        check_i("fill_accepts", n_acc, 66);
        step(1'b0, 1'b0);
        check_i("full_wr_prdy", int'(wr_prdy), 0);
        check_i("full_count", int'(count), 66);
        repeat (3) step(1'b0, 1'b0);
        check_i("full_hold_wr_prdy", int'(wr_prdy), 0);
        check_i("full_hold_count", int'(count), 66);
        check_i("full_sb_count", int'(count), sb_q.size());

        // Pop one, then write into the freed slot immediately
        step(1'b0, 1'b1);
        n_acc = 0;
        step(1'b1, 1'b0);
        check_i("refill_wr_prdy", int'(wr_prdy), 1);
        check_i("refill_accept", n_acc, 1);
        step(1'b0, 1'b0);
        check_i("refull_count", int'(count), 66);
        check_i("refull_wr_prdy", int'(wr_prdy), 0);
        drain("full");

        // Continuous streaming across the pointer wrap
        do_reset();
        set_seq(1000);
        steady = 0;
        for (int i = 0; i < 200; i++) begin
            step(1'b1, 1'b1);
            if (i >= 5 && rd_pvld) steady++;
            if (i >= 5) check_i("stream_count", int'(count), sb_q.size());
        end
        check_i("stream_steady_outputs", steady, 195);
        drain("stream");

        // Random valid/ready toggling with random data
        do_reset();
        rand_mode = 1'b1;
        cur_data  = next_data();
        for (int i = 0; i < 5000; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check_i("rand_count", int'(count), sb_q.size());
        end
        drain("rand");

        // Reset with entries held and a read in flight
        do_reset();
        set_seq(1);
        n_acc = 0;
        k = 0;
        while (n_acc < 11 && k < 100) begin
            step(1'b1, 1'b0);
            k++;
        end
        step(1'b0, 1'b1);
        @(negedge clk);
        rd_prdy = 1'b0;
        wr_pvld = 1'b1;
        check_i("pre_rst_count", int'(count), 10);
        #1 rst = 1'b1;
        #1;
        check_i("midrst_wr_prdy", int'(wr_prdy), 0);
        check_i("midrst_rd_pvld", int'(rd_pvld), 0);
        check_i("midrst_count", int'(count), 0);
        check_i("midrst_ram_we", int'(ram_we), 0);
        check_i("midrst_ram_re", int'(ram_re), 0);
        check_d("midrst_rd_pd", rd_pd, '0);
        repeat (2) @(negedge clk);
        wr_pvld = 1'b0;
        rst     = 1'b0;
        set_seq(10);
        pop0  = n_pop;
        n_acc = 0;
        k = 0;
        while (n_acc < 2 && k < 20) begin
            step(1'b1, 1'b1);
            k++;
        end
        drain("post_rst");
        check_i("post_rst_outputs", n_pop - pop0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
